// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: forwarding selects, stall/flush, mult/div busy tracking.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       pc_src_d,
  input  logic       hilo_read_d,
  input  logic       md_op_d,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       md_busy,
  output logic       md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic lw_stall, br_stall, md_stall, any_stall;
  logic x_e, x_m;

  // Forwarding: M has priority over W; register 0 never forwards.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (rs_e != '0 && reg_write_m && write_reg_m == rs_e)      forward_a_e = 2'b10;
    else if (rs_e != '0 && reg_write_w && write_reg_w == rs_e) forward_a_e = 2'b01;
    if (rt_e != '0 && reg_write_m && write_reg_m == rt_e)      forward_b_e = 2'b10;
    else if (rt_e != '0 && reg_write_w && write_reg_w == rt_e) forward_b_e = 2'b01;
  end

  assign forward_a_d = reg_write_m && (write_reg_m == rs_d) && (rs_d != '0);
  assign forward_b_d = reg_write_m && (write_reg_m == rt_d) && (rt_d != '0);

  assign lw_stall = mem_to_reg_e && (write_reg_e != '0) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign x_e      = reg_write_e && (write_reg_e != '0) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign x_m      = mem_to_reg_m && (write_reg_m != '0) &&
                    ((write_reg_m == rs_d) || (write_reg_m == rt_d));
  assign br_stall = branch_d && (x_e || x_m);
  assign md_stall = (hilo_read_d || md_op_d) && (md_busy || md_start_e);

  assign any_stall = lw_stall | br_stall | md_stall;
  assign stall_f   = any_stall;
  assign stall_d   = any_stall;
  assign flush_e   = any_stall;
  assign flush_d   = pc_src_d && !any_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (md_start_e) begin
          state_nxt = BUSY;
          cnt_nxt   = md_is_div_e ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        // A new start while busy is dropped; decode stalls keep it from happening.
        if (cnt == '0) begin
          md_done   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d) stall_cnt <= stall_cnt + 32'd1;
      if (flush_d) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard cases plus randomized stimulus
// checked against a cycle-count reference model of the mult/div unit.
module tb_hazard_ctrl;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, pc_src_d, hilo_read_d, md_op_d, md_start_e, md_is_div_e;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic       forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       md_busy, md_done;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .pc_src_d(pc_src_d), .hilo_read_d(hilo_read_d),
    .md_op_d(md_op_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles of the mult/div unit, and event totals.
  int          busy_left = 0;
  logic [31:0] stall_total = '0;
  logic [31:0] flush_total = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit hits_d(input logic [4:0] r);
    return (r != 5'd0) && (r == rs_d || r == rt_d);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (reg_write_m && write_reg_m == src) return 2'b10;
    if (reg_write_w && write_reg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    lw = mem_to_reg_e && hits_d(write_reg_e);
    br = branch_d && ((reg_write_e && hits_d(write_reg_e)) || (mem_to_reg_m && hits_d(write_reg_m)));
    md = (hilo_read_d || md_op_d) && (busy_left > 0 || md_start_e);
    return lw || br || md;
  endfunction

  task automatic check_all(input string tag);
    bit st;
    st = exp_stall();
    check_eq({tag, ".stall_f"}, 32'(stall_f), 32'(st));
    check_eq({tag, ".stall_d"}, 32'(stall_d), 32'(st));
    check_eq({tag, ".flush_e"}, 32'(flush_e), 32'(st));
    check_eq({tag, ".flush_d"}, 32'(flush_d), 32'(pc_src_d && !st));
    check_eq({tag, ".fwd_a_d"}, 32'(forward_a_d), 32'(reg_write_m && rs_d != 0 && write_reg_m == rs_d));
    check_eq({tag, ".fwd_b_d"}, 32'(forward_b_d), 32'(reg_write_m && rt_d != 0 && write_reg_m == rt_d));
    check_eq({tag, ".fwd_a_e"}, 32'(forward_a_e), 32'(fwd_e(rs_e)));
    check_eq({tag, ".fwd_b_e"}, 32'(forward_b_e), 32'(fwd_e(rt_e)));
    check_eq({tag, ".md_busy"}, 32'(md_busy), 32'(busy_left > 0));
    check_eq({tag, ".md_done"}, 32'(md_done), 32'(busy_left == 1));
`ifdef HAZARD_PERF_EN
    check_eq({tag, ".stall_cnt"}, stall_cnt, stall_total);
    check_eq({tag, ".flush_cnt"}, flush_cnt, flush_total);
`else
    check_eq({tag, ".stall_cnt"}, stall_cnt, 32'd0);
    check_eq({tag, ".flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  // Advance one clock and the model with it; returns #1 after the edge.
  task automatic tick();
    bit st, fl;
    st = exp_stall();
    fl = pc_src_d && !st;
    @(posedge clk);
    if (rst) begin
      if (busy_left > 0) busy_left--;
      else if (md_start_e) busy_left = md_is_div_e ? DIV_LAT : MULT_LAT;
      if (st) stall_total = stall_total + 32'd1;
      if (fl) flush_total = flush_total + 32'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    {rs_d, rt_d, rs_e, rt_e} = '0;
    {write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w} = '0;
    {mem_to_reg_e, mem_to_reg_m} = '0;
    {branch_d, pc_src_d, hilo_read_d, md_op_d, md_start_e, md_is_div_e} = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #12;
    check_eq("rst.md_busy", 32'(md_busy), 32'd0);
    check_eq("rst.md_done", 32'(md_done), 32'd0);
    check_all("rst");
    rst = 1'b1;
    tick();

    // Load-use
    mem_to_reg_e = 1; write_reg_e = 8; rs_d = 8; #1;
    check_eq("lu.stall_d", 32'(stall_d), 32'd1);
    check_eq("lu.fwd_a_e", 32'(forward_a_e), 32'd0);
    check_all("lu");
    tick();
    write_reg_e = 0; rs_d = 0; #1;
    check_eq("lu0.stall_d", 32'(stall_d), 32'd0);
    check_all("lu0");
    tick();

    // Forwarding priority M over W
    idle_inputs();
    reg_write_m = 1; reg_write_w = 1; write_reg_m = 5; write_reg_w = 5; rs_e = 5; #1;
    check_eq("fp.m", 32'(forward_a_e), 32'd2);
    check_all("fp.m");
    reg_write_m = 0; #1;
    check_eq("fp.w", 32'(forward_a_e), 32'd1);
    check_all("fp.w");
    tick();

    // Branch hazard then taken branch
    idle_inputs();
    branch_d = 1; reg_write_e = 1; write_reg_e = 3; rt_d = 3; #1;
    check_eq("br.stall", 32'(stall_d), 32'd1);
    check_all("br");
    tick();
    reg_write_e = 0; pc_src_d = 1; #1;
    check_eq("br.flush_d", 32'(flush_d), 32'd1);
    check_eq("br.stall_d", 32'(stall_d), 32'd0);
    check_all("br.taken");
    tick();

    // Div occupancy with hilo read held
    idle_inputs();
    md_start_e = 1; md_is_div_e = 1; #1;
    tick();
    md_start_e = 0; md_is_div_e = 0; hilo_read_d = 1; #1;
    for (int i = 1; i <= int'(DIV_LAT); i++) begin
      check_eq("div.busy", 32'(md_busy), 32'd1);
      check_eq("div.stall", 32'(stall_d), 32'd1);
      check_eq("div.done", 32'(md_done), 32'(i == int'(DIV_LAT)));
      check_all("div");
      tick();
    end
    check_eq("div.after_busy", 32'(md_busy), 32'd0);
    check_eq("div.after_stall", 32'(stall_d), 32'd0);
    check_all("div.after");

    // Reset mid-BUSY
    idle_inputs();
    md_start_e = 1; md_is_div_e = 1; #1;
    tick();
    md_start_e = 0; md_is_div_e = 0;
    for (int i = 0; i < 9; i++) tick();
    check_eq("rmb.pre_busy", 32'(md_busy), 32'd1);
    rst = 1'b0; #1;
    busy_left = 0; stall_total = '0; flush_total = '0;
    check_eq("rmb.busy", 32'(md_busy), 32'd0);
    check_eq("rmb.done", 32'(md_done), 32'd0);
    tick();
    check_eq("rmb.hold_busy", 32'(md_busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rmb.idle", 32'(md_busy), 32'd0);
      check_eq("rmb.nodone", 32'(md_done), 32'd0);
    end

    // Randomized traffic with small register space to provoke matches
    for (int n = 0; n < 3000; n++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      write_reg_e = 5'($urandom_range(0, 3));
      write_reg_m = 5'($urandom_range(0, 3));
      write_reg_w = 5'($urandom_range(0, 3));
      reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      mem_to_reg_e = ($urandom_range(0, 3) == 0);
      mem_to_reg_m = ($urandom_range(0, 3) == 0);
      branch_d = ($urandom_range(0, 3) == 0);
      pc_src_d = ($urandom_range(0, 3) == 0);
      hilo_read_d = ($urandom_range(0, 7) == 0);
      md_op_d = ($urandom_range(0, 7) == 0);
      md_start_e = ($urandom_range(0, 7) == 0);
      md_is_div_e = ($urandom_range(0, 3) == 0);
      #1;
      check_all("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
